jtag_reg_ctrl: RTL and testbench
================================

// Module: jtag_reg_ctrl
// PURPOSE
//   Command controller behind the two JTAGG user chains (ER1/ER2), all in the JTCK domain.
//   Each chain shifts in a command word. On Update-DR the command is queued for that chain.
//   A round-robin executor serialises the two queues onto one shared register file.
//   The register file drives LEDS and LEDS_columns, and read data is returned on the next capture.
// PARAMETERS
//   DATA_W    16        data field width (>= 9)
//   ADDR_W    2         address field width; 4 registers decoded
//   ID_VALUE  16'hE5C0  constant returned by reads of address 3
// PORTS
//   JTCK          in   1       JTAG clock; all state on rising edge
//   JRSTN         in   1       async active-low reset
//   JTDI          in   1       serial data in, shared by both chains
//   JSHIFT        in   1       Shift-DR active
//   JUPDATE       in   1       Update-DR pulse, shared by both chains
//   JCE1/JCE2     in   1       chain 1/2 enable (capture or shift of ER1/ER2)
//   JRTI1/JRTI2   in   1       Run-Test/Idle with ER1/ER2; ignored by logic, clocks supplied there
//   JTD1/JTD2     out  1       serial data out of chain 1/2 (= shift reg bit 0)
//   LEDS          out  9       register 0, bits [8:0]
//   LEDS_columns  out  4       register 1, bits [3:0]
//   busy          out  1       either queue pending or executor not IDLE
// BEHAVIOUR
//   - W = 1+ADDR_W+DATA_W (19). Command layout:
//       bit 0: rw (1 = write, 0 = read)
//       bits [ADDR_W:1]: addr
//       bits [W-1:ADDR_W+1]: data
//   - Shift:
//       - JCE_n & JSHIFT: sr_n <= {JTDI, sr_n[W-1:1]}, LSB first.
//       - JTD_n = sr_n[0], combinational from the register.
//   - Capture (JCE_n & !JSHIFT) loads sr_n with:
//       - [0] = !req_n (done); [1] = ovf_n; [2] = err_n
//       - [3+:DATA_W] = rdata_n; remaining bits 0
//       - ovf_n and err_n clear on capture; a same-edge set wins over the clear.
//   - Chain select: sel_n <= 1 on any cycle with JCE_n; both sel flags clear on JUPDATE.
//   - Update:
//       - JUPDATE & sel_n & !req_n: cmd_n <= sr_n, req_n <= 1.
//       - If req_n is already set: command dropped, ovf_n <= 1.
//       - If no sel flag is set: ignored.
//   - Executor FSM, states IDLE and EXEC:
//       - IDLE: if any req is set, grant one and go to EXEC.
//       - Both set: grant the chain that is NOT last_grant (last_grant resets to 2, so chain 1 wins first).
//       - EXEC: perform the command, clear req_g, update last_grant, return to IDLE.
//   - Latency: req set at edge k -> EXEC at k+1 -> register/LED/rdata update at k+2.
//     Loser of a tie completes at k+4.
//   - Register map (writes take the low bits of data; reads zero-extend to DATA_W):
//       - 0: LEDS [8:0]
//       - 1: LEDS_columns [3:0]
//       - 2: scratch [DATA_W-1:0]
//       - 3: ID_VALUE, read-only; a write is ignored and sets err_g
//       - addr >= 4 (ADDR_W > 2): read returns 0 and sets err_g
//   - A read writes rdata_g only. A write leaves rdata_g unchanged.
//   - JUPDATE on chain g during its own EXEC edge: new command is accepted (req re-set), no ovf.
//   - Reset (JRSTN low, async, any time, including mid-EXEC):
//       - all sr, cmd, req, sel, flags, rdata, scratch, LEDS, LEDS_columns = 0
//       - FSM = IDLE, last_grant = 2; JTD1 = JTD2 = 0, busy = 0
//       - in-flight commands are lost.
// TESTING
//   - Reset: JRSTN low mid-shift -> LEDS=0, LEDS_columns=0, JTD1=JTD2=0, busy=0.
//   - Chain1 write: shift 19 bits (rw=1, addr=0, data=16'h01A5), then JUPDATE
//     -> LEDS=9'h1A5 two JTCK edges later; next capture bit0=1.
//   - Chain2 read: read of addr 3 -> next chain2 capture shifts out done=1, ovf=0, err=0, data=16'hE5C0.
//   - Tie: both queues loaded before the executor runs (chain1 writes addr1=4'hA, chain2 writes addr1=4'h5)
//     -> chain1 executes first, final LEDS_columns=4'h5; swap order on the next tie.
//   - Overflow: second chain1 update while req1 is pending (JTCK held idle)
//     -> first command executes, second dropped; next capture ovf=1, the following capture ovf=0.
//   - Error: write to addr 3 -> ID is unchanged on readback, err=1 once, then cleared.

Source files
------------

// File: rtl/jtag_reg_ctrl_if.sv
// JTAG user-chain pins (ER1/ER2) plus the register-file outputs they control.
// Latency: wires only, no storage.
// Backpressure: none at this level; the controller flags overflow itself.
interface jtag_reg_ctrl_if;
    logic       JTDI;
    logic       JSHIFT;
    logic       JUPDATE;
    logic       JCE1;
    logic       JCE2;
    logic       JRTI1;
    logic       JRTI2;
    logic       JTD1;
    logic       JTD2;
    logic [8:0] LEDS;
    logic [3:0] LEDS_columns;
    logic       busy;

    // TAP / test side drives the chain controls and observes the outputs
    modport master (
        output JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2,
        input  JTD1, JTD2, LEDS, LEDS_columns, busy
    );

    // controller side
    modport slave (
        input  JTDI, JSHIFT, JUPDATE, JCE1, JCE2, JRTI1, JRTI2,
        output JTD1, JTD2, LEDS, LEDS_columns, busy
    );
endinterface

// File: rtl/jtag_reg_ctrl.sv
// Two JTAG user-chain command queues serialised round-robin onto one register file.
// Latency: request set at edge k, executor in EXEC at k+1, register/rdata updated at k+2.
// Backpressure: one slot per chain; an update while that slot is full is dropped and flags ovf.
module jtag_reg_ctrl #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 2,
    parameter logic [DATA_W-1:0] ID_VALUE = 16'hE5C0
) (
    input  logic           JTCK,
    input  logic           JRSTN,
    jtag_reg_ctrl_if.slave bus
);
    localparam int W = 1 + ADDR_W + DATA_W;

    typedef enum logic {S_IDLE = 1'b0, S_EXEC = 1'b1} state_t;

    // per-chain state, index 0 = chain 1 (ER1), index 1 = chain 2 (ER2)
    logic [W-1:0]      r_sr    [2];
    logic [W-1:0]      r_cmd   [2];
    logic [DATA_W-1:0] r_rdata [2];
    logic [1:0]        r_req;
    logic [1:0]        r_sel;
    logic [1:0]        r_ovf;
    logic [1:0]        r_err;

    // shared register file
    logic [8:0]        r_leds;
    logic [3:0]        r_cols;
    logic [DATA_W-1:0] r_scratch;

    // executor
    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_grant;        // chain under execution: 0 = chain 1, 1 = chain 2
    logic              w_grant_nxt;
    logic              r_last_grant;   // chain executed most recently

    logic [1:0]        w_ce;
    logic [1:0]        w_capture;
    logic [1:0]        w_done;
    logic [1:0]        w_accept;
    logic [1:0]        w_drop;
    logic [1:0]        w_err_set;
    logic [W-1:0]      w_cap [2];
    logic              w_exec;
    logic [W-1:0]      w_cmd;
    logic              w_rw;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_val;
    logic              w_acc_err;
    logic              w_unused;

    assign w_ce    = {bus.JCE2, bus.JCE1};
    assign w_exec  = (r_state == S_EXEC);
    assign w_cmd   = r_cmd[r_grant];
    assign w_rw    = w_cmd[0];
    assign w_addr  = w_cmd[ADDR_W:1];
    assign w_wdata = w_cmd[W-1:ADDR_W+1];

    // Run-Test/Idle only supplies clocks; the logic does not look at it
    assign w_unused = &{1'b0, bus.JRTI1, bus.JRTI2};

    // per-chain capture word and queue-slot decisions
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_capture[n] = w_ce[n] & ~bus.JSHIFT;
            w_done[n]    = w_exec & (r_grant == 1'(n));
            // the slot frees on the very edge its command executes, so an update there is taken
            w_accept[n]  = bus.JUPDATE & r_sel[n] & (~r_req[n] | w_done[n]);
            w_drop[n]    = bus.JUPDATE & r_sel[n] & r_req[n] & ~w_done[n];
            w_err_set[n] = w_done[n] & w_acc_err;
            w_cap[n]               = '0;
            w_cap[n][0]            = ~r_req[n];
            w_cap[n][1]            = r_ovf[n];
            w_cap[n][2]            = r_err[n];
            w_cap[n][3 +: DATA_W]  = r_rdata[n];
        end
    end

    // register map decode for the command under execution
    always_comb begin
        w_rd_val  = '0;
        w_acc_err = 1'b0;
        case (w_addr)
            ADDR_W'(0): w_rd_val = DATA_W'(r_leds);
            ADDR_W'(1): w_rd_val = DATA_W'(r_cols);
            ADDR_W'(2): w_rd_val = r_scratch;
            ADDR_W'(3): begin
                w_rd_val  = ID_VALUE;
                w_acc_err = w_rw;
            end
            default:    w_acc_err = 1'b1;
        endcase
    end

    // shift registers, chain select, command slots, status flags, read data
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            for (int n = 0; n < 2; n++) begin
                r_sr[n]    <= '0;
                r_cmd[n]   <= '0;
                r_rdata[n] <= '0;
            end
            r_req <= '0;
            r_sel <= '0;
            r_ovf <= '0;
            r_err <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_ce[n]) begin
                    r_sr[n] <= bus.JSHIFT ? {bus.JTDI, r_sr[n][W-1:1]} : w_cap[n];
                end
                if (bus.JUPDATE) begin
                    r_sel[n] <= 1'b0;
                end else if (w_ce[n]) begin
                    r_sel[n] <= 1'b1;
                end
                if (w_accept[n]) begin
                    r_cmd[n] <= r_sr[n];
                    r_req[n] <= 1'b1;
                end else if (w_done[n]) begin
                    r_req[n] <= 1'b0;
                end
                // a set on the capture edge survives the capture clear
                if (w_drop[n]) begin
                    r_ovf[n] <= 1'b1;
                end else if (w_capture[n]) begin
                    r_ovf[n] <= 1'b0;
                end
                if (w_err_set[n]) begin
                    r_err[n] <= 1'b1;
                end else if (w_capture[n]) begin
                    r_err[n] <= 1'b0;
                end
                if (w_done[n] && !w_rw) begin
                    r_rdata[n] <= w_rd_val;
                end
            end
        end
    end

    // register file writes from the executing command
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_leds    <= '0;
            r_cols    <= '0;
            r_scratch <= '0;
        end else if (w_exec && w_rw) begin
            case (w_addr)
                ADDR_W'(0): r_leds    <= w_wdata[8:0];
                ADDR_W'(1): r_cols    <= w_wdata[3:0];
                ADDR_W'(2): r_scratch <= w_wdata;
                default:    ;
            endcase
        end
    end

    // executor state register; last_grant resets to chain 2 so chain 1 wins the first tie
    always_ff @(posedge JTCK or negedge JRSTN) begin
        if (!JRSTN) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_exec) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // executor next state: grant one pending chain, alternating on a tie
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            S_IDLE: begin
                if (|r_req) begin
                    w_state_nxt = S_EXEC;
                    w_grant_nxt = (&r_req) ? ~r_last_grant : r_req[1];
                end
            end
            S_EXEC: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.JTD1         = r_sr[0][0];
    assign bus.JTD2         = r_sr[1][0];
    assign bus.LEDS         = r_leds;
    assign bus.LEDS_columns = r_cols;
    assign bus.busy         = (|r_req) | (r_state != S_IDLE);
endmodule

// File: tb/tb_jtag_reg_ctrl.sv
// Directed bench for jtag_reg_ctrl with a queue-based scoreboard.
// Stimulus pushes expected capture words, LED/column changes (value and edge) and snapshots.
// A negedge monitor pops and compares whenever the DUT shifts out a frame or changes an output.
module tb_jtag_reg_ctrl;
    localparam int W = 19;

    typedef struct {
        logic [15:0] v;
        int          c;
    } chg_t;

    logic JTCK;
    logic JRSTN;
    jtag_reg_ctrl_if bus ();

    jtag_reg_ctrl #(.DATA_W(16), .ADDR_W(2), .ID_VALUE(16'hE5C0)) dut (
        .JTCK (JTCK),
        .JRSTN(JRSTN),
        .bus  (bus)
    );

    initial JTCK = 1'b0;
    always #5 JTCK = ~JTCK;

    int cyc = 0;
    always @(posedge JTCK) cyc <= cyc + 1;

    int          ntests = 0;
    int          nfail  = 0;
    logic [W-1:0] capq1[$];
    logic [W-1:0] capq2[$];
    chg_t        ledq[$];
    chg_t        colq[$];
    logic [15:0] snapq[$];
    logic        snap_vld  = 1'b0;
    logic        drain_req = 1'b0;
    logic        drain_ack = 1'b0;

    // monitor-side state
    logic [8:0]   prev_leds;
    logic [3:0]   prev_cols;
    logic [W-1:0] acc1, acc2;
    int           cnt1 = 0;
    int           cnt2 = 0;
    logic [15:0]  act_snap, exp_snap;
    logic [W-1:0] exp_w;
    chg_t         ev;

    function automatic logic [W-1:0] cmd(input logic rw, input logic [1:0] a, input logic [15:0] d);
        return {d, a, rw};
    endfunction

    function automatic logic [W-1:0] cap(input logic [15:0] d, input logic e, input logic o, input logic dn);
        return {d, e, o, dn};
    endfunction

    task automatic chk_cap(input int ch, input logic [W-1:0] act);
        ntests++;
        if ((ch == 1 && capq1.size() == 0) || (ch == 2 && capq2.size() == 0)) begin
            nfail++;
            $display("FAIL cap%0d: shifted out %h with no expectation queued", ch, act);
        end else begin
            exp_w = (ch == 1) ? capq1.pop_front() : capq2.pop_front();
            if (act !== exp_w) begin
                nfail++;
                $display("FAIL cap%0d: got %h required %h", ch, act, exp_w);
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge JTCK) begin
        if (snap_vld) begin
            ntests++;
            act_snap = {bus.LEDS, bus.LEDS_columns, bus.JTD1, bus.JTD2, bus.busy};
            if (snapq.size() == 0) begin
                nfail++;
                $display("FAIL snap: got %h with no expectation queued", act_snap);
            end else begin
                exp_snap = snapq.pop_front();
                if (act_snap !== exp_snap) begin
                    nfail++;
                    $display("FAIL snap: got {leds,cols,jtd1,jtd2,busy}=%h required %h", act_snap, exp_snap);
                end
            end
        end
        if (!JRSTN) begin
            prev_leds = bus.LEDS;
            prev_cols = bus.LEDS_columns;
            cnt1 = 0;
            cnt2 = 0;
        end else begin
            if (bus.LEDS !== prev_leds) begin
                ntests++;
                if (ledq.size() == 0) begin
                    nfail++;
                    $display("FAIL leds: changed to %h at cycle %0d, no change expected", bus.LEDS, cyc);
                end else begin
                    ev = ledq.pop_front();
                    if (bus.LEDS !== ev.v[8:0] || cyc != ev.c) begin
                        nfail++;
                        $display("FAIL leds: got %h at cycle %0d required %h at cycle %0d", bus.LEDS, cyc, ev.v[8:0], ev.c);
                    end
                end
                prev_leds = bus.LEDS;
            end
            if (bus.LEDS_columns !== prev_cols) begin
                ntests++;
                if (colq.size() == 0) begin
                    nfail++;
                    $display("FAIL cols: changed to %h at cycle %0d, no change expected", bus.LEDS_columns, cyc);
                end else begin
                    ev = colq.pop_front();
                    if (bus.LEDS_columns !== ev.v[3:0] || cyc != ev.c) begin
                        nfail++;
                        $display("FAIL cols: got %h at cycle %0d required %h at cycle %0d", bus.LEDS_columns, cyc, ev.v[3:0], ev.c);
                    end
                end
                prev_cols = bus.LEDS_columns;
            end
            if (bus.JCE1 && bus.JSHIFT) begin
                acc1[cnt1] = bus.JTD1;
                cnt1++;
                if (cnt1 == W) begin
                    cnt1 = 0;
                    chk_cap(1, acc1);
                end
            end
            if (bus.JCE2 && bus.JSHIFT) begin
                acc2[cnt2] = bus.JTD2;
                cnt2++;
                if (cnt2 == W) begin
                    cnt2 = 0;
                    chk_cap(2, acc2);
                end
            end
        end
        if (drain_req && !drain_ack) begin
            ntests++;
            if (capq1.size() + capq2.size() + ledq.size() + colq.size() + snapq.size() != 0) begin
                nfail++;
                $display("FAIL drain: %0d expectations never matched, required 0",
                         capq1.size() + capq2.size() + ledq.size() + colq.size() + snapq.size());
            end
            drain_ack = 1'b1;
        end
    end

    task automatic set_ce(input int ch, input logic v);
        if (ch == 1) bus.JCE1 = v;
        else         bus.JCE2 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge JTCK);
        #1;
    endtask

    task automatic snap(input logic [15:0] e);
        snapq.push_back(e);
        snap_vld = 1'b1;
        @(posedge JTCK);
        #1;
        snap_vld = 1'b0;
    endtask

    task automatic exp_led(input logic [8:0] v, input int c);
        chg_t e;
        e.v = {7'd0, v};
        e.c = c;
        ledq.push_back(e);
    endtask

    task automatic exp_col(input logic [3:0] v, input int c);
        chg_t e;
        e.v = {12'd0, v};
        e.c = c;
        colq.push_back(e);
    endtask

    // capture, shift W bits LSB first, then an optional Update-DR; ucyc is the
    // cycle count while the update is driven (update edge = ucyc + 1)
    task automatic frame(input int ch, input logic [W-1:0] word, input logic upd,
                         input logic [W-1:0] exp_cap, output int ucyc);
        if (ch == 1) capq1.push_back(exp_cap);
        else         capq2.push_back(exp_cap);
        @(posedge JTCK); #1;
        set_ce(ch, 1'b1);
        bus.JSHIFT = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(posedge JTCK); #1;
            bus.JSHIFT = 1'b1;
            bus.JTDI   = word[i];
        end
        @(posedge JTCK); #1;
        set_ce(ch, 1'b0);
        bus.JSHIFT  = 1'b0;
        bus.JTDI    = 1'b0;
        bus.JUPDATE = upd;
        ucyc = cyc;
        @(posedge JTCK); #1;
        bus.JUPDATE = 1'b0;
    endtask

    int u;

    initial begin
        bus.JTDI = 1'b0; bus.JSHIFT = 1'b0; bus.JUPDATE = 1'b0;
        bus.JCE1 = 1'b0; bus.JCE2 = 1'b0; bus.JRTI1 = 1'b0; bus.JRTI2 = 1'b0;
        JRSTN = 1'b1;
        #2 JRSTN = 1'b0;
        repeat (2) @(posedge JTCK);
        #1;
        snap(16'h0000);
        JRSTN = 1'b1;
        idle(2);

        // chain 1 write LEDS = 1A5; two edges after update; busy right after update
        frame(1, cmd(1'b1, 2'd0, 16'h01A5), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        exp_led(9'h1A5, u + 3);
        snap({9'h000, 4'h0, 1'b1, 1'b0, 1'b1});
        idle(4);
        frame(1, cmd(1'b1, 2'd2, 16'h1234), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(1, cmd(1'b0, 2'd2, 16'h0), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(1, cmd(1'b0, 2'd0, 16'h0), 1'b1, cap(16'h1234, 1'b0, 1'b0, 1'b1), u);
        idle(4);

        // chain 2 reads ID, then sees it on the next capture
        frame(2, cmd(1'b0, 2'd3, 16'h0), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(2, cmd(1'b0, 2'd1, 16'h0), 1'b1, cap(16'hE5C0, 1'b0, 1'b0, 1'b1), u);
        idle(4);

        // tie 1: both slots loaded by one update; chain 1 first (A), chain 2 second (5)
        frame(1, cmd(1'b1, 2'd1, 16'h000A), 1'b0, cap(16'h01A5, 1'b0, 1'b0, 1'b1), u);
        frame(2, cmd(1'b1, 2'd1, 16'h0005), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        exp_col(4'hA, u + 3);
        exp_col(4'h5, u + 5);
        idle(6);

        // lone chain 1 read makes chain 1 the last grant, so the next tie goes to chain 2
        frame(1, cmd(1'b0, 2'd1, 16'h0), 1'b1, cap(16'h01A5, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(1, cmd(1'b1, 2'd1, 16'h0003), 1'b0, cap(16'h0005, 1'b0, 1'b0, 1'b1), u);
        frame(2, cmd(1'b1, 2'd1, 16'h000C), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        exp_col(4'hC, u + 3);
        exp_col(4'h3, u + 5);
        idle(6);

        // overflow: chain 1 loses a tie, a second chain 1 update lands while its slot is full
        frame(1, cmd(1'b1, 2'd0, 16'h00F0), 1'b0, cap(16'h0005, 1'b0, 1'b0, 1'b1), u);
        frame(2, cmd(1'b1, 2'd2, 16'hBEEF), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        exp_led(9'h0F0, u + 5);
        bus.JCE1 = 1'b1;
        @(posedge JTCK); #1;
        bus.JCE1    = 1'b0;
        bus.JUPDATE = 1'b1;
        @(posedge JTCK); #1;
        bus.JUPDATE = 1'b0;
        idle(6);
        frame(1, cmd(1'b0, 2'd0, 16'h0), 1'b1, cap(16'h0005, 1'b0, 1'b1, 1'b1), u);
        idle(4);
        frame(1, cmd(1'b0, 2'd2, 16'h0), 1'b1, cap(16'h00F0, 1'b0, 1'b0, 1'b1), u);
        idle(4);

        // error: write to the ID register is ignored and flags err once
        frame(2, cmd(1'b1, 2'd3, 16'h1234), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(2, cmd(1'b0, 2'd3, 16'h0), 1'b1, cap(16'h0, 1'b1, 1'b0, 1'b1), u);
        idle(4);
        frame(2, cmd(1'b0, 2'd2, 16'h0), 1'b1, cap(16'hE5C0, 1'b0, 1'b0, 1'b1), u);
        idle(4);
        frame(2, cmd(1'b0, 2'd0, 16'h0), 1'b1, cap(16'hBEEF, 1'b0, 1'b0, 1'b1), u);
        idle(4);

        // reset in the middle of a chain 1 shift
        @(posedge JTCK); #1;
        bus.JCE1   = 1'b1;
        bus.JSHIFT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge JTCK); #1;
            bus.JSHIFT = 1'b1;
            bus.JTDI   = 1'b1;
        end
        JRSTN      = 1'b0;
        bus.JCE1   = 1'b0;
        bus.JSHIFT = 1'b0;
        bus.JTDI   = 1'b0;
        snap(16'h0000);
        JRSTN = 1'b1;
        idle(2);
        frame(1, cmd(1'b0, 2'd0, 16'h0), 1'b1, cap(16'h0, 1'b0, 1'b0, 1'b1), u);
        idle(6);
        snap(16'h0000);

        idle(4);
        drain_req = 1'b1;
        repeat (3) @(posedge JTCK);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
